// File: rtl/tile_scheduler_if.sv
// Configuration and pass-handshake bundle between the host side and the tile scheduler.
// The slave modport is the scheduler; the master modport is the host/router side.
interface tile_scheduler_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  i_start;
  logic [CNT_WIDTH-1:0]  i_num_filters;
  logic [CNT_WIDTH-1:0]  i_num_tiles;
  logic [ADDR_WIDTH-1:0] i_w_base;
  logic [ADDR_WIDTH-1:0] i_w_stride;
  logic [ADDR_WIDTH-1:0] i_i_base;
  logic [ADDR_WIDTH-1:0] i_i_stride;
  logic [ADDR_WIDTH-1:0] i_i_len;
  logic                  i_pass_done;
  logic                  o_route_en;
  logic [ADDR_WIDTH-1:0] o_w_start_addr;
  logic [ADDR_WIDTH-1:0] o_i_start_addr;
  logic [ADDR_WIDTH-1:0] o_i_addr_end;
  logic [CNT_WIDTH-1:0]  o_filter_idx;
  logic [CNT_WIDTH-1:0]  o_tile_idx;
  logic                  o_busy;
  logic                  o_done;

  modport slave (
    input  i_start, i_num_filters, i_num_tiles, i_w_base, i_w_stride,
           i_i_base, i_i_stride, i_i_len, i_pass_done,
    output o_route_en, o_w_start_addr, o_i_start_addr, o_i_addr_end,
           o_filter_idx, o_tile_idx, o_busy, o_done
  );

  modport master (
    output i_start, i_num_filters, i_num_tiles, i_w_base, i_w_stride,
           i_i_base, i_i_stride, i_i_len, i_pass_done,
    input  o_route_en, o_w_start_addr, o_i_start_addr, o_i_addr_end,
           o_filter_idx, o_tile_idx, o_busy, o_done
  );
endinterface

// File: rtl/tile_scheduler.sv
// Walks filters (outer) and input tiles (inner) of a convolution layer, launching one
// routing pass per (filter, tile) and waiting for its completion before advancing.
module tile_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_reg_clear,
  tile_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_filters_q, num_filters_d;
  logic [CNT_WIDTH-1:0]  num_tiles_q, num_tiles_d;
  logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
  logic [ADDR_WIDTH-1:0] w_stride_q, w_stride_d;
  logic [ADDR_WIDTH-1:0] i_base_q, i_base_d;
  logic [ADDR_WIDTH-1:0] i_stride_q, i_stride_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] w_start_q, w_start_d;
  logic [ADDR_WIDTH-1:0] i_start_q, i_start_d;
  logic [ADDR_WIDTH-1:0] i_end_q, i_end_d;
  logic [CNT_WIDTH-1:0]  filter_q, filter_d;
  logic [CNT_WIDTH-1:0]  tile_q, tile_d;
  logic [ADDR_WIDTH-1:0] next_i_start;

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      state_q       <= S_IDLE;
      num_filters_q <= '0;
      num_tiles_q   <= '0;
      w_base_q      <= '0;
      w_stride_q    <= '0;
      i_base_q      <= '0;
      i_stride_q    <= '0;
      len_q         <= '0;
      w_start_q     <= '0;
      i_start_q     <= '0;
      i_end_q       <= '0;
      filter_q      <= '0;
      tile_q        <= '0;
    end else begin
      state_q       <= state_d;
      num_filters_q <= num_filters_d;
      num_tiles_q   <= num_tiles_d;
      w_base_q      <= w_base_d;
      w_stride_q    <= w_stride_d;
      i_base_q      <= i_base_d;
      i_stride_q    <= i_stride_d;
      len_q         <= len_d;
      w_start_q     <= w_start_d;
      i_start_q     <= i_start_d;
      i_end_q       <= i_end_d;
      filter_q      <= filter_d;
      tile_q        <= tile_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    num_filters_d = num_filters_q;
    num_tiles_d   = num_tiles_q;
    w_base_d      = w_base_q;
    w_stride_d    = w_stride_q;
    i_base_d      = i_base_q;
    i_stride_d    = i_stride_q;
    len_d         = len_q;
    w_start_d     = w_start_q;
    i_start_d     = i_start_q;
    i_end_d       = i_end_q;
    filter_d      = filter_q;
    tile_d        = tile_q;
    next_i_start  = i_start_q + i_stride_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          num_filters_d = bus.i_num_filters;
          num_tiles_d   = bus.i_num_tiles;
          w_base_d      = bus.i_w_base;
          w_stride_d    = bus.i_w_stride;
          i_base_d      = bus.i_i_base;
          i_stride_d    = bus.i_i_stride;
          len_d         = bus.i_i_len;
          if (bus.i_num_filters == '0 || bus.i_num_tiles == '0) state_d = S_DONE;
          else                                                   state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        filter_d  = '0;
        tile_d    = '0;
        w_start_d = w_base_q;
        i_start_d = i_base_q;
        i_end_d   = i_base_q + len_q - ADDR_WIDTH'(1);
        state_d   = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_pass_done) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        // Addresses update on the edge leaving ADVANCE so they are stable through WAIT.
        if (tile_q < num_tiles_q - CNT_WIDTH'(1)) begin
          tile_d    = tile_q + CNT_WIDTH'(1);
          i_start_d = next_i_start;
          i_end_d   = next_i_start + len_q - ADDR_WIDTH'(1);
          state_d   = S_ISSUE;
        end else if (filter_q < num_filters_q - CNT_WIDTH'(1)) begin
          tile_d    = '0;
          filter_d  = filter_q + CNT_WIDTH'(1);
          w_start_d = w_start_q + w_stride_q;
          i_start_d = i_base_q;
          i_end_d   = i_base_q + len_q - ADDR_WIDTH'(1);
          state_d   = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Indices hold through DONE and read zero once back in IDLE.
        filter_d  = '0;
        tile_d    = '0;
        w_start_d = '0;
        i_start_d = '0;
        i_end_d   = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_route_en     = (state_q == S_ISSUE);
  assign bus.o_done         = (state_q == S_DONE);
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_w_start_addr = w_start_q;
  assign bus.o_i_start_addr = i_start_q;
  assign bus.o_i_addr_end   = i_end_q;
  assign bus.o_filter_idx   = filter_q;
  assign bus.o_tile_idx     = tile_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: expected passes are queued when a layer is started
// and popped as each route_en appears.
module tb_tile_scheduler;

  logic clk = 1'b0;
  logic nrst;
  logic reg_clear;

  always #5 clk = ~clk;

  tile_scheduler_if #(.ADDR_WIDTH(8), .CNT_WIDTH(8)) bus ();

  tile_scheduler #(.ADDR_WIDTH(8), .CNT_WIDTH(8)) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_reg_clear (reg_clear),
    .bus         (bus)
  );

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] t;
    logic [7:0] w;
    logic [7:0] is;
    logic [7:0] ie;
  } pass_t;

  pass_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_route_en"}, 32'(bus.o_route_en), 0);
    chk({tag, "_busy"},     32'(bus.o_busy), 0);
    chk({tag, "_done"},     32'(bus.o_done), 0);
    chk({tag, "_w"},        32'(bus.o_w_start_addr), 0);
    chk({tag, "_is"},       32'(bus.o_i_start_addr), 0);
    chk({tag, "_ie"},       32'(bus.o_i_addr_end), 0);
    chk({tag, "_fidx"},     32'(bus.o_filter_idx), 0);
    chk({tag, "_tidx"},     32'(bus.o_tile_idx), 0);
  endtask

  task automatic set_cfg(input int nf, input int nt, input int wb, input int ws,
                         input int ib, input int is, input int len);
    bus.i_num_filters = 8'(nf);
    bus.i_num_tiles   = 8'(nt);
    bus.i_w_base      = 8'(wb);
    bus.i_w_stride    = 8'(ws);
    bus.i_i_base      = 8'(ib);
    bus.i_i_stride    = 8'(is);
    bus.i_i_len       = 8'(len);
  endtask

  // Reference model: absolute addresses from base + index*stride, wrapped to 8 bits.
  task automatic push_layer(input int nf, input int nt, input int wb, input int ws,
                            input int ib, input int is, input int len);
    pass_t p;
    exp_q.delete();
    for (int f = 0; f < nf; f++) begin
      for (int t = 0; t < nt; t++) begin
        p.f  = 8'(f);
        p.t  = 8'(t);
        p.w  = 8'((wb + f * ws) % 256);
        p.is = 8'((ib + t * is) % 256);
        p.ie = 8'((ib + t * is + len - 1) % 256);
        exp_q.push_back(p);
      end
    end
  endtask

  // Pulse i_start or i_pass_done for one cycle, then count cycles until route_en or done.
  task automatic pulse_wait(input bit is_start, input bit want_done, output int n);
    if (is_start) bus.i_start = 1'b1;
    else          bus.i_pass_done = 1'b1;
    tick();
    bus.i_start     = 1'b0;
    bus.i_pass_done = 1'b0;
    n = 1;
    while (!(want_done ? bus.o_done : bus.o_route_en) && n < 40) begin
      tick();
      n++;
    end
  endtask

  // mode 0: plain; mode 1: spurious pass_done in ISSUE and i_start in WAIT;
  // mode 2: scramble config inputs right after start.
  task automatic run_layer(input string tag, input int mode);
    pass_t e;
    int    n;
    int    stray_route;
    bit    first;
    first = 1'b1;
    pulse_wait(1'b1, 1'b0, n);
    chk({tag, "_start_lat"}, 32'(n), 2);
    if (mode == 2) set_cfg(7, 7, 200, 33, 99, 17, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_route_en"}, 32'(bus.o_route_en), 1);
      chk({tag, "_fidx"}, 32'(bus.o_filter_idx), 32'(e.f));
      chk({tag, "_tidx"}, 32'(bus.o_tile_idx), 32'(e.t));
      chk({tag, "_w"},    32'(bus.o_w_start_addr), 32'(e.w));
      chk({tag, "_is"},   32'(bus.o_i_start_addr), 32'(e.is));
      chk({tag, "_ie"},   32'(bus.o_i_addr_end), 32'(e.ie));
      if (mode == 1 && first) bus.i_pass_done = 1'b1;
      tick();
      bus.i_pass_done = 1'b0;
      chk({tag, "_route_pulse"}, 32'(bus.o_route_en), 0);
      stray_route = 0;
      for (int k = 0; k < 4; k++) begin
        if (mode == 1 && first && k == 1) bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        stray_route += int'(bus.o_route_en) + int'(bus.o_done);
      end
      chk({tag, "_hold_wait"}, 32'(stray_route), 0);
      chk({tag, "_hold_busy"}, 32'(bus.o_busy), 1);
      chk({tag, "_hold_fidx"}, 32'(bus.o_filter_idx), 32'(e.f));
      chk({tag, "_hold_tidx"}, 32'(bus.o_tile_idx), 32'(e.t));
      chk({tag, "_hold_is"},   32'(bus.o_i_start_addr), 32'(e.is));
      chk({tag, "_hold_w"},    32'(bus.o_w_start_addr), 32'(e.w));
      first = 1'b0;
      if (exp_q.size() == 0) begin
        pulse_wait(1'b0, 1'b1, n);
        chk({tag, "_done_lat"}, 32'(n), 2);
        chk({tag, "_done_fidx"}, 32'(bus.o_filter_idx), 32'(e.f));
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.o_done), 0);
        chk({tag, "_idle_busy"},  32'(bus.o_busy), 0);
        chk({tag, "_idle_fidx"},  32'(bus.o_filter_idx), 0);
        chk({tag, "_idle_tidx"},  32'(bus.o_tile_idx), 0);
      end else begin
        pulse_wait(1'b0, 1'b0, n);
        chk({tag, "_pass_lat"}, 32'(n), 2);
      end
      $display("%s pass f=%0d t=%0d w=%0d is=%0d ie=%0d", tag, e.f, e.t, e.w, e.is, e.ie);
    end
  endtask

  // Start the basic layer, reach WAIT of pass (0,1), then abort with reset or clear.
  task automatic abort_layer(input string tag, input bit use_clear);
    int n;
    int done_cnt;
    pulse_wait(1'b1, 1'b0, n);
    chk({tag, "_p0_tidx"}, 32'(bus.o_tile_idx), 0);
    tick();
    tick();
    pulse_wait(1'b0, 1'b0, n);
    chk({tag, "_p1_tidx"}, 32'(bus.o_tile_idx), 1);
    tick();
    tick();
    if (use_clear) reg_clear = 1'b1;
    else           nrst = 1'b0;
    tick();
    reg_clear = 1'b0;
    nrst      = 1'b1;
    chk_zero_outputs(tag);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      done_cnt += int'(bus.o_done) + int'(bus.o_route_en) + int'(bus.o_busy);
    end
    chk({tag, "_quiet"}, 32'(done_cnt), 0);
    $display("%s aborted in WAIT of pass (0,1)", tag);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int route_cnt;

    nrst            = 1'b0;
    reg_clear       = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_pass_done = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    nrst = 1'b1;
    chk_zero_outputs("reset");
    $display("reset outputs checked");

    // Stray pass_done while idle
    bus.i_pass_done = 1'b1;
    tick();
    bus.i_pass_done = 1'b0;
    tick();
    chk("idle_pd_busy", 32'(bus.o_busy), 0);
    chk("idle_pd_route", 32'(bus.o_route_en), 0);
    $display("idle pass_done ignored");

    set_cfg(2, 3, 0, 9, 16, 4, 6);
    push_layer(2, 3, 0, 9, 16, 4, 6);
    run_layer("basic", 0);

    set_cfg(0, 5, 0, 9, 16, 4, 6);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    route_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      busy_cnt  += int'(bus.o_busy);
      done_cnt  += int'(bus.o_done);
      route_cnt += int'(bus.o_route_en);
      tick();
    end
    chk("zero_busy_cycles", 32'(busy_cnt), 1);
    chk("zero_done_pulses", 32'(done_cnt), 1);
    chk("zero_route_pulses", 32'(route_cnt), 0);
    $display("zero count busy=%0d done=%0d route=%0d", busy_cnt, done_cnt, route_cnt);

    set_cfg(1, 2, 5, 3, 250, 4, 8);
    push_layer(1, 2, 5, 3, 250, 4, 8);
    run_layer("wrap", 0);

    set_cfg(2, 3, 0, 9, 16, 4, 6);
    push_layer(2, 3, 0, 9, 16, 4, 6);
    run_layer("spurious", 1);

    set_cfg(2, 3, 0, 9, 16, 4, 6);
    abort_layer("nrst_abort", 1'b0);
    push_layer(2, 3, 0, 9, 16, 4, 6);
    run_layer("after_nrst", 0);

    set_cfg(2, 3, 0, 9, 16, 4, 6);
    abort_layer("clear_abort", 1'b1);
    set_cfg(3, 2, 40, 250, 100, 200, 10);
    push_layer(3, 2, 40, 250, 100, 200, 10);
    run_layer("cfg_change", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
